// File: rtl/jtopl_slot_sched.sv
// Operator slot counter and CPU register-write scheduler.
// Holds one write until its slot reaches the shift-register input.
module jtopl_slot_sched #(
   parameter int SLOTS = 18,
   parameter int AW    = 5,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen,
   input  logic          wr_req,
   input  logic [AW-1:0] wr_slot,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ack,
   output logic          wr_err,
   output logic          busy,
   output logic [AW-1:0] slot,
   output logic          zero,
   output logic          upd_en,
   output logic [DW-1:0] upd_data
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACK
   } state_t;

   localparam logic [AW-1:0] LAST  = AW'(SLOTS - 1);
   localparam logic [AW:0]   NSLOT = (AW + 1)'(SLOTS);

   state_t        state;
   logic [AW-1:0] tgt;

   assign zero   = (slot == '0);
   assign upd_en = (state == WAIT) && (slot == tgt);

   // Slot counter: one step per cen, wrapping after the last slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot <= '0;
      end else if (cen) begin
         slot <= (slot == LAST) ? '0 : slot + AW'(1);
      end
   end

   // Request FSM: latch, wait for the target slot on a cen, then ack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         tgt      <= '0;
         upd_data <= '0;
         busy     <= 1'b0;
         wr_ack   <= 1'b0;
         wr_err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (wr_req) begin
                  tgt      <= wr_slot;
                  upd_data <= wr_data;
                  if ({1'b0, wr_slot} >= NSLOT) begin
                     state  <= ACK;
                     wr_ack <= 1'b1;
                     wr_err <= 1'b1;
                  end else begin
                     state <= WAIT;
                     busy  <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (cen && slot == tgt) begin
                  state  <= ACK;
                  busy   <= 1'b0;
                  wr_ack <= 1'b1;
                  wr_err <= 1'b0;
               end
            end
            ACK: begin
               if (!wr_req) begin
                  state  <= IDLE;
                  wr_ack <= 1'b0;
                  wr_err <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               wr_ack <= 1'b0;
               wr_err <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtopl_slot_sched.sv
// Bench for jtopl_slot_sched: vector table plus
// hand sequences for slow cen and reset abort.
module tb_jtopl_slot_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cen;
   logic       wr_req;
   logic [4:0] wr_slot;
   logic [7:0] wr_data;
   logic       wr_ack;
   logic       wr_err;
   logic       busy;
   logic [4:0] slot;
   logic       zero;
   logic       upd_en;
   logic [7:0] upd_data;

   jtopl_slot_sched #(.SLOTS(18), .AW(5), .DW(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cen      (cen),
      .wr_req   (wr_req),
      .wr_slot  (wr_slot),
      .wr_data  (wr_data),
      .wr_ack   (wr_ack),
      .wr_err   (wr_err),
      .busy     (busy),
      .slot     (slot),
      .zero     (zero),
      .upd_en   (upd_en),
      .upd_data (upd_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] slot;
      logic [7:0] data;
   } upd_t;

   upd_t sb[$];

   typedef struct {
      logic [4:0] tgt;
      logic [7:0] data;
      logic [4:0] start;
      logic       err;
      int         wait_n;
      logic [4:0] after;
   } vec_t;

   vec_t vecs[7];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // one clock: drive cen, observe update at negedge, return #1 after posedge
   task automatic step(input logic c, output logic hit, output logic seen);
      upd_t e;
      cen = c;
      @(negedge clk);
      seen = upd_en;
      hit  = upd_en && c;
      if (hit) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_upd: slot %0d data %0h, none expected",
                     slot, upd_data);
         end else begin
            e = sb.pop_front();
            if (slot !== e.slot || upd_data !== e.data) begin
               errors++;
               $display("FAIL upd_match: slot %0d data %0h expected %0d %0h",
                        slot, upd_data, e.slot, e.data);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_slot(input logic [4:0] s);
      logic h, sn;
      for (int i = 0; i < 40 && slot != s; i++) step(1'b1, h, sn);
      chk("reach_slot", 32'(slot), 32'(s));
   endtask

   initial begin
      logic       h, sn;
      int         n, en_cnt, cen_hits, k;
      logic [4:0] exp_slot;
      upd_t       u;

      vecs[0] = '{tgt: 5'd5,  data: 8'hA3, start: 5'd2,  err: 1'b0,
                  wait_n: 3,  after: 5'd6};
      vecs[1] = '{tgt: 5'd2,  data: 8'h5C, start: 5'd2,  err: 1'b0,
                  wait_n: 18, after: 5'd3};
      vecs[2] = '{tgt: 5'd0,  data: 8'h11, start: 5'd15, err: 1'b0,
                  wait_n: 3,  after: 5'd1};
      vecs[3] = '{tgt: 5'd17, data: 8'h7E, start: 5'd0,  err: 1'b0,
                  wait_n: 17, after: 5'd0};
      vecs[4] = '{tgt: 5'd20, data: 8'h33, start: 5'd7,  err: 1'b1,
                  wait_n: 0,  after: 5'd0};
      vecs[5] = '{tgt: 5'd18, data: 8'h44, start: 5'd3,  err: 1'b1,
                  wait_n: 0,  after: 5'd0};
      vecs[6] = '{tgt: 5'd31, data: 8'hFF, start: 5'd12, err: 1'b1,
                  wait_n: 0,  after: 5'd0};

      rst_n   = 1'b0;
      cen     = 1'b0;
      wr_req  = 1'b0;
      wr_slot = '0;
      wr_data = '0;
      #12;
      chk("rst_slot", 32'(slot), 0);
      chk("rst_zero", 32'(zero), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ack", 32'(wr_ack), 0);
      chk("rst_err", 32'(wr_err), 0);
      chk("rst_upd_en", 32'(upd_en), 0);
      chk("rst_upd_data", 32'(upd_data), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // free-running counter, no requests
      exp_slot = 5'd0;
      n = 0;
      for (int i = 0; i < 37; i++) begin
         step(1'b1, h, sn);
         exp_slot = (exp_slot == 5'd17) ? 5'd0 : exp_slot + 5'd1;
         if (zero) n++;
         chk("free_slot", 32'(slot), 32'(exp_slot));
         chk("free_zero", 32'(zero), 32'(exp_slot == 5'd0));
         chk("free_idle", 32'({busy, upd_en, wr_ack}), 0);
      end
      chk("free_zero_cnt", n, 2);

      // vector table, cen every clk
      for (int v = 0; v < 7; v++) begin
         wait_slot(vecs[v].start);
         wr_req  = 1'b1;
         wr_slot = vecs[v].tgt;
         wr_data = vecs[v].data;
         if (!vecs[v].err) begin
            u.slot = vecs[v].tgt;
            u.data = vecs[v].data;
            sb.push_back(u);
         end
         step(1'b1, h, sn);
         wr_slot = 5'd9;
         wr_data = 8'hEE;
         if (vecs[v].err) begin
            chk("err_ack", 32'(wr_ack), 1);
            chk("err_err", 32'(wr_err), 1);
            chk("err_busy", 32'(busy), 0);
            en_cnt = 0;
            for (int i = 0; i < 20; i++) begin
               step(1'b1, h, sn);
               if (sn) en_cnt++;
            end
            chk("err_no_upd", en_cnt, 0);
            chk("err_ack_hold", 32'({wr_ack, wr_err}), 3);
         end else begin
            chk("lat_busy", 32'(busy), 1);
            chk("lat_ack", 32'(wr_ack), 0);
            n = 0;
            h = 1'b0;
            while (!h && n < 40) begin
               step(1'b1, h, sn);
               n++;
            end
            chk("wait_len", n, vecs[v].wait_n);
            chk("done_ack", 32'(wr_ack), 1);
            chk("done_err", 32'(wr_err), 0);
            chk("done_busy", 32'(busy), 0);
            chk("done_slot", 32'(slot), 32'(vecs[v].after));
            step(1'b1, h, sn);
            chk("ack_hold", 32'(wr_ack), 1);
         end
         wr_req = 1'b0;
         step(1'b1, h, sn);
         chk("rel_ack", 32'(wr_ack), 0);
         chk("rel_err", 32'(wr_err), 0);
         chk("rel_busy", 32'(busy), 0);
      end

      // slot 17 with cen every 4th clk
      wait_slot(5'd10);
      wr_req  = 1'b1;
      wr_slot = 5'd17;
      wr_data = 8'hC7;
      u.slot  = 5'd17;
      u.data  = 8'hC7;
      sb.push_back(u);
      step(1'b0, h, sn);
      chk("slow_latch_slot", 32'(slot), 10);
      en_cnt   = 0;
      cen_hits = 0;
      k        = 0;
      while (!wr_ack && k < 200) begin
         step(k % 4 == 3, h, sn);
         if (sn) en_cnt++;
         if (h) cen_hits++;
         k++;
      end
      chk("slow_en_clks", en_cnt, 4);
      chk("slow_cen_hits", cen_hits, 1);
      chk("slow_wrap", 32'(slot), 0);
      chk("slow_ack", 32'(wr_ack), 1);
      wr_req = 1'b0;
      step(1'b0, h, sn);
      chk("slow_rel", 32'(wr_ack), 0);

      // reset while waiting on slot 9
      wait_slot(5'd2);
      wr_req  = 1'b1;
      wr_slot = 5'd9;
      wr_data = 8'h99;
      step(1'b1, h, sn);
      chk("rst_mid_busy", 32'(busy), 1);
      step(1'b1, h, sn);
      step(1'b1, h, sn);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_slot", 32'(slot), 0);
      chk("rst_mid_outs",
          32'({busy, wr_ack, wr_err, upd_en}), 0);
      chk("rst_mid_data", 32'(upd_data), 0);
      wr_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      en_cnt = 0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step(1'b1, h, sn);
         if (sn) en_cnt++;
         if (wr_ack) n++;
      end
      chk("rst_mid_no_upd", en_cnt, 0);
      chk("rst_mid_no_ack", n, 0);
      sb.delete();

      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: sim time limit reached, required $finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/jtopl_slot_sched.md
Name: jtopl_slot_sched

Overview:
Slot scheduler for the operator pipeline built from per-slot shift registers. It owns the slot counter that names the operator currently at the shift-register input stage. It also accepts single register-write requests from the CPU interface through a 4-phase handshake. It holds each request until the targeted slot reaches the input stage, then drives the one-slot update strobe and data that the shift-register din mux consumes.

Parameters:
SLOTS, 18, number of operator slots (pipeline stages); must be greater than 2
AW, 5, slot index width; 2**AW >= SLOTS
DW, 8, register write data width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
cen  in  1  clock enable; the pipeline advances one slot per cen cycle
wr_req  in  1  write request level (4-phase)
wr_slot  in  AW  target slot of the request
wr_data  in  DW  data to insert for the target slot
wr_ack  out  1  request completed; held until wr_req drops
wr_err  out  1  valid with wr_ack; target slot was >= SLOTS, no update done
busy  out  1  a request is latched and pending
slot  out  AW  slot index currently at the shift-register input
zero  out  1  high while slot==0
upd_en  out  1  select upd_data instead of recirculated data this slot
upd_data  out  DW  latched write data

Behaviour:
- Reset (rst_n low, async): slot=0, state=IDLE, wr_ack=0, wr_err=0, busy=0, upd_en=0, upd_data=0. zero=1 follows from slot=0.
- Slot counter:
  - On clk with cen: slot <= (slot==SLOTS-1) ? 0 : slot+1.
  - Without cen, slot holds.
  - zero is a combinational decode of slot.
- FSM states: IDLE, WAIT, ACK. State transitions happen on every clk, not only cen cycles.
- IDLE:
  - If wr_req=1, latch tgt<=wr_slot and upd_data<=wr_data.
  - If wr_slot >= SLOTS, go to ACK with wr_err=1.
  - Otherwise go to WAIT with busy=1.
- WAIT:
  - upd_en = (slot==tgt) as a combinational decode of registered state. It is never asserted outside WAIT.
  - On a clk with cen=1 and slot==tgt: the datapath samples upd_data for that slot. Go to ACK with busy=0 and wr_err=0.
  - If cen=0 while slot==tgt, stay in WAIT with upd_en held high. Exactly one cen cycle ever sees upd_en per request.
  - Changes on wr_slot/wr_data in WAIT are ignored.
  - wr_req dropping in WAIT does not abort the request.
- ACK:
  - wr_ack=1.
  - When wr_req=0, go to IDLE and clear wr_ack and wr_err.
  - A new request needs wr_req low for at least one clk.
- Latency:
  - IDLE to WAIT takes 1 clk.
  - The update then happens within 1..SLOTS cen pulses.
  - If tgt equals the current slot at latch time and cen is not asserted in the latching cycle, the update occurs on the next cen.
  - If cen is asserted in the latching cycle, the slot advances and the wait is SLOTS cen pulses.
- Wrap-around: tgt=SLOTS-1 updates on the cen where slot goes SLOTS-1 -> 0. tgt=0 updates while zero=1.
- Simultaneous events: a request latched on a clk where cen=1 is compared against the post-increment slot.
- Reset mid-operation: the pending request is discarded with no upd_en and no wr_ack. The requester must re-issue.
- upd_data keeps its last value after completion. It only has meaning while upd_en=1.

Test Plan:
- Reset then free-running cen every clk, no requests -> slot sequence 0,1,...,17,0; zero high once every 18 cen; busy/upd_en/wr_ack stay 0.
- Request wr_slot=5, wr_data=8'hA3, issued while slot=2, cen every clk -> busy=1 next clk. upd_en=1 exactly while slot==5 with upd_data=A3. wr_ack rises the clk after that cen, busy falls. Release wr_req -> wr_ack=0 next clk.
- Request wr_slot=17, cen every 4th clk -> upd_en high for 4 clks while slot==17, data sampled on the single cen; slot wraps to 0 on the same cen; one ack.
- Request wr_slot=20 -> no upd_en ever; wr_ack=1 and wr_err=1 one clk after latch; both clear after wr_req drops.
- Request wr_slot equal to the current slot, with cen asserted in the latch cycle -> update occurs 18 cen pulses later, not immediately.
- Deassert rst_n while in WAIT with tgt=9 -> all outputs 0 immediately and slot=0; after release, no upd_en at slot 9 and no wr_ack.
